dmem_request_unit: RTL and testbench

DMEM_REQUEST_UNIT -- requirements
Module: dmem_request_unit

---
 rtl/dmem_request_unit_pkg.sv | 24 ++
 rtl/dmem_request_unit_if.sv | 24 ++
 rtl/dmem_request_unit_store_lane_aligner.sv | 48 ++++
 rtl/dmem_request_unit.sv | 111 +++++++++++
 tb/tb_dmem_request_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_request_unit_pkg.sv
// Shared definitions for the data-memory request unit: datapath width,
// one-hot access-width encodings and the request FSM state encoding.
package dmem_request_unit_pkg;

    localparam int XLEN = 64;

    // One-hot access widths as produced by the decoder.
    localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
    localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
    localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
    localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // True when exactly one bit of a 4-bit vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/dmem_request_unit_if.sv
// Data-memory request/response bus. The request unit is the master; the
// memory system (or a testbench) is the slave.
interface dmem_request_unit_if;
    import dmem_request_unit_pkg::*;

    logic            req;     // request pending
    logic            we;      // store when 1, load when 0
    logic [XLEN-1:0] addr;    // doubleword-aligned address
    logic [7:0]      be;      // byte enables within the doubleword
    logic [XLEN-1:0] wdata;   // lane-replicated store data
    logic            gnt;     // request accepted by memory
    logic            rvalid;  // response valid

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid
    );

endinterface

// File: rtl/dmem_request_unit_store_lane_aligner.sv
// Combinational lane alignment: builds the byte-enable mask and replicated
// write data for an access, and reports whether the access is naturally
// aligned and whether its width encoding is legal.
module store_lane_aligner
    import dmem_request_unit_pkg::*;
(
    input  logic [2:0]      byte_addr_i,
    input  logic [3:0]      mem_width_1h_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [7:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            width_legal_o,
    output logic            aligned_o
);

    // Width decode: mask shifted to the byte lane, data replicated across lanes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        be_o          = 8'h00;
        wdata_o       = store_data_i;
        aligned_o     = 1'b0;
        width_legal_o = is_onehot4(mem_width_1h_i);
        case (mem_width_1h_i)
            MEM_WIDTH_1H_BYTE: begin
                be_o      = 8'h01 << byte_addr_i;
                wdata_o   = {8{store_data_i[7:0]}};
                aligned_o = 1'b1;
            end
            MEM_WIDTH_1H_HALF: begin
                be_o      = 8'h03 << byte_addr_i;
                wdata_o   = {4{store_data_i[15:0]}};
                aligned_o = ~byte_addr_i[0];
            end
            MEM_WIDTH_1H_WORD: begin
                be_o      = 8'h0F << byte_addr_i;
                wdata_o   = {2{store_data_i[31:0]}};
                aligned_o = (byte_addr_i[1:0] == 2'b00);
            end
            MEM_WIDTH_1H_DOUBLE: begin
                be_o      = 8'hFF;
                wdata_o   = store_data_i;
                aligned_o = (byte_addr_i == 3'b000);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_request_unit.sv
// Memory-stage data request unit: accepts one load/store at a time from the
// pipeline, issues it on the dmem bus, stalls the pipeline until the
// response arrives and flags misaligned accesses.
module dmem_request_unit
    import dmem_request_unit_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic                squash_i,
    input  logic                mem_rd_en_i,
    input  logic                mem_wr_en_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     store_data_i,
    input  logic [3:0]          mem_width_1h_i,
    dmem_request_unit_if.master dmem,
    output logic [2:0]          byte_addr_o,
    output logic                stall_o,
    output logic                misaligned_o
);

    state_e          state_q, state_d;
    logic [7:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic            width_legal;
    logic            aligned;
    logic            access_req;
    logic            accept;

    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [7:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      byte_addr_q;

    store_lane_aligner u_aligner (
        .byte_addr_i    (addr_i[2:0]),
        .mem_width_1h_i (mem_width_1h_i),
        .store_data_i   (store_data_i),
        .be_o           (be_c),
        .wdata_o        (wdata_c),
        .width_legal_o  (width_legal),
        .aligned_o      (aligned)
    );

    // A live memory op in IDLE; qualified by rst_ni so accept, stall and the
    // misaligned flag stay quiet while reset is held.
    assign access_req   = rst_ni && (state_q == ST_IDLE) && valid_i &&
                          (mem_rd_en_i || mem_wr_en_i) && !squash_i && width_legal;
    assign accept       = access_req && aligned;
    assign misaligned_o = access_req && !aligned;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline stall. A squash in REQ only drops the request
    // when memory has not granted it in the same cycle; once in WAIT the
    // transaction always runs to its response.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                stall_o = accept;
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dmem.gnt)      state_d = ST_WAIT;
                else if (squash_i) state_d = ST_IDLE;
            end
            ST_WAIT: begin
                stall_o = !dmem.rvalid;
                if (dmem.rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at accept and hold it until the next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 8'h00;
            wdata_q     <= '0;
            byte_addr_q <= 3'b000;
        end else if (accept) begin
            we_q        <= mem_wr_en_i;
            addr_q      <= {addr_i[XLEN-1:3], 3'b000};
            be_q        <= be_c;
            wdata_q     <= wdata_c;
            byte_addr_q <= addr_i[2:0];
        end
    end

    assign dmem.req    = (state_q == ST_REQ);
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.be     = be_q;
    assign dmem.wdata  = wdata_q;
    assign byte_addr_o = byte_addr_q;

endmodule

// File: tb/tb_dmem_request_unit.sv
// Self-checking bench for dmem_request_unit: directed scenarios followed by
// randomized accesses checked against a behavioural model of lane rules.
module tb_dmem_request_unit;
    import dmem_request_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid, squash, rd_en, wr_en;
    logic [63:0]     addr, sdata;
    logic [3:0]      width;
    logic [2:0]      byte_addr;
    logic            stall, misaligned;

    int checks = 0;
    int errors = 0;

    dmem_request_unit_if dmem_if ();

    dmem_request_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .valid_i        (valid),
        .squash_i       (squash),
        .mem_rd_en_i    (rd_en),
        .mem_wr_en_i    (wr_en),
        .addr_i         (addr),
        .store_data_i   (sdata),
        .mem_width_1h_i (width),
        .dmem           (dmem_if),
        .byte_addr_o    (byte_addr),
        .stall_o        (stall),
        .misaligned_o   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int width_bytes(input logic [3:0] w);
        case (w)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_be(input logic [63:0] a, input int nb);
        int m;
        if (nb == 8) return 8'hFF;
        m = ((1 << nb) - 1) << int'(a[2:0]);
        return m[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input int nb);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; squash = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},   64'(dmem_if.req),   64'd0);
        check({tag, ".we"},    64'(dmem_if.we),    64'd0);
        check({tag, ".addr"},  dmem_if.addr,       64'd0);
        check({tag, ".be"},    64'(dmem_if.be),    64'd0);
        check({tag, ".wdata"}, dmem_if.wdata,      64'd0);
        check({tag, ".baddr"}, 64'(byte_addr),     64'd0);
        check({tag, ".stall"}, 64'(stall),         64'd0);
        check({tag, ".mis"},   64'(misaligned),    64'd0);
    endtask

    // One access through the whole handshake; expectations come from the model.
    task automatic do_access(input string tag, input logic wr, input logic [63:0] a,
                             input logic [63:0] d, input logic [3:0] w, input logic sq,
                             input int gnt_dly, input int rv_dly, input logic noise);
        int          nb;
        logic        legal, al, acc, mis;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd, exp_addr;
        nb       = width_bytes(w);
        legal    = (nb != 0);
        al       = legal && ((int'(a[2:0]) % (legal ? nb : 1)) == 0);
        acc      = legal && al && !sq;
        mis      = legal && !al && !sq;
        exp_be   = legal ? model_be(a, nb) : 8'h00;
        exp_wd   = legal ? model_wdata(d, nb) : 64'd0;
        exp_addr = {a[63:3], 3'b000};

        drive_edge();
        valid = 1'b1; squash = sq; rd_en = !wr; wr_en = wr;
        addr = a; sdata = d; width = w;
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
        @(negedge clk);
        check({tag, ".issue.stall"}, 64'(stall),        64'(acc));
        check({tag, ".issue.mis"},   64'(misaligned),   64'(mis));
        check({tag, ".issue.req"},   64'(dmem_if.req),  64'd0);

        if (!acc) begin
            drive_edge();
            idle_inputs();
            @(negedge clk);
            check({tag, ".noacc.req"},   64'(dmem_if.req), 64'd0);
            check({tag, ".noacc.stall"}, 64'(stall),       64'd0);
            check({tag, ".noacc.mis"},   64'(misaligned),  64'd0);
            return;
        end

        for (int k = 0; k <= gnt_dly; k++) begin
            drive_edge();
            idle_inputs();
            dmem_if.gnt    = (k == gnt_dly);
            dmem_if.rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check({tag, ".req.req"},   64'(dmem_if.req),   64'd1);
            check({tag, ".req.stall"}, 64'(stall),         64'd1);
            check({tag, ".req.we"},    64'(dmem_if.we),    64'(wr));
            check({tag, ".req.addr"},  dmem_if.addr,       exp_addr);
            check({tag, ".req.be"},    64'(dmem_if.be),    64'(exp_be));
            check({tag, ".req.wdata"}, dmem_if.wdata,      wr ? exp_wd : dmem_if.wdata);
            check({tag, ".req.baddr"}, 64'(byte_addr),     64'(a[2:0]));
        end

        for (int k = 0; k <= rv_dly; k++) begin
            drive_edge();
            dmem_if.gnt    = 1'b0;
            dmem_if.rvalid = (k == rv_dly);
            squash         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check({tag, ".wait.req"},   64'(dmem_if.req), 64'd0);
            check({tag, ".wait.stall"}, 64'(stall),       64'(k != rv_dly));
            check({tag, ".wait.baddr"}, 64'(byte_addr),   64'(a[2:0]));
        end

        drive_edge();
        idle_inputs();
        @(negedge clk);
        check({tag, ".done.req"},   64'(dmem_if.req), 64'd0);
        check({tag, ".done.stall"}, 64'(stall),       64'd0);
        check({tag, ".done.baddr"}, 64'(byte_addr),   64'(a[2:0]));
    endtask

    initial begin
        logic        r_wr, r_sq;
        logic [63:0] r_addr, r_data;
        logic [3:0]  r_w;
        int          sel;

        idle_inputs();
        addr = 64'd0; sdata = 64'd0; width = 4'b0001;
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Store byte, zero-wait.
        do_access("sb", 1'b1, 64'h1005, 64'hAB, MEM_WIDTH_1H_BYTE, 1'b0, 0, 0, 1'b0);
        check("sb.be",    64'(dmem_if.be), 64'h20);
        check("sb.wdata", dmem_if.wdata,   64'hABABABABABABABAB);
        check("sb.addr",  dmem_if.addr,    64'h1000);

        // Load half, grant delayed three cycles.
        do_access("lh", 1'b0, 64'h2006, 64'h0, MEM_WIDTH_1H_HALF, 1'b0, 3, 0, 1'b0);
        check("lh.be",    64'(dmem_if.be), 64'hC0);
        check("lh.baddr", 64'(byte_addr),  64'd6);

        // Misaligned store word: flagged, never requested.
        do_access("swmis", 1'b1, 64'h3002, 64'h11223344, MEM_WIDTH_1H_WORD, 1'b0, 0, 0, 1'b0);
        drive_edge();
        @(negedge clk);
        check("swmis.later.req", 64'(dmem_if.req), 64'd0);

        // Non-one-hot widths are ignored.
        do_access("w0",  1'b1, 64'h40, 64'h5, 4'b0000, 1'b0, 0, 0, 1'b0);
        do_access("w6",  1'b0, 64'h41, 64'h5, 4'b0110, 1'b0, 0, 0, 1'b0);

        // Store double.
        do_access("sd", 1'b1, 64'h8, 64'h0123456789ABCDEF, MEM_WIDTH_1H_DOUBLE, 1'b0, 1, 2, 1'b0);
        check("sd.be",    64'(dmem_if.be), 64'hFF);
        check("sd.wdata", dmem_if.wdata,   64'h0123456789ABCDEF);

        // Squash in REQ without grant: request dropped next cycle.
        drive_edge();
        valid = 1'b1; rd_en = 1'b1; addr = 64'h50; width = MEM_WIDTH_1H_DOUBLE;
        @(negedge clk);
        check("sq1.accept.stall", 64'(stall), 64'd1);
        drive_edge();
        idle_inputs();
        squash = 1'b1;
        @(negedge clk);
        check("sq1.req.req", 64'(dmem_if.req), 64'd1);
        drive_edge();
        squash = 1'b0;
        @(negedge clk);
        check("sq1.after.req",   64'(dmem_if.req), 64'd0);
        check("sq1.after.stall", 64'(stall),       64'd0);

        // Squash coincident with grant: transaction committed, waits for rvalid.
        drive_edge();
        valid = 1'b1; rd_en = 1'b1; addr = 64'h60; width = MEM_WIDTH_1H_DOUBLE;
        @(negedge clk);
        drive_edge();
        idle_inputs();
        squash = 1'b1; dmem_if.gnt = 1'b1;
        @(negedge clk);
        check("sq2.req.stall", 64'(stall), 64'd1);
        drive_edge();
        dmem_if.gnt = 1'b0;
        @(negedge clk);
        check("sq2.wait.req",   64'(dmem_if.req), 64'd0);
        check("sq2.wait.stall", 64'(stall),       64'd1);
        drive_edge();
        @(negedge clk);
        check("sq2.wait2.stall", 64'(stall), 64'd1);
        drive_edge();
        dmem_if.rvalid = 1'b1;
        @(negedge clk);
        check("sq2.rvalid.stall", 64'(stall), 64'd0);
        drive_edge();
        idle_inputs();
        @(negedge clk);
        check("sq2.idle.stall", 64'(stall),       64'd0);
        check("sq2.idle.req",   64'(dmem_if.req), 64'd0);

        // rvalid while idle is ignored.
        drive_edge();
        dmem_if.rvalid = 1'b1;
        @(negedge clk);
        check("stray.stall", 64'(stall), 64'd0);
        drive_edge();
        dmem_if.rvalid = 1'b0;
        @(negedge clk);
        check("stray.req", 64'(dmem_if.req), 64'd0);

        // Reset asserted in WAIT.
        drive_edge();
        valid = 1'b1; wr_en = 1'b1; addr = 64'h1008; sdata = 64'hDEADBEEF; width = MEM_WIDTH_1H_WORD;
        @(negedge clk);
        drive_edge();
        idle_inputs();
        dmem_if.gnt = 1'b1;
        @(negedge clk);
        drive_edge();
        dmem_if.gnt = 1'b0;
        @(negedge clk);
        check("rstw.wait.stall", 64'(stall), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        drive_edge();
        @(negedge clk);
        check("rstw.after.req",   64'(dmem_if.req), 64'd0);
        check("rstw.after.stall", 64'(stall),       64'd0);
        do_access("rstw.ld", 1'b0, 64'h2004, 64'h0, MEM_WIDTH_1H_WORD, 1'b0, 0, 1, 1'b0);

        // Randomized accesses against the model.
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = {$urandom, $urandom};
            r_data = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) r_addr[2:0] = 3'b000;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       r_w = 4'(4'b0001 << (sel % 4));
            else if (sel == 8) r_w = 4'b0000;
            else               r_w = 4'b0110;
            r_sq = ($urandom_range(0, 7) == 0);
            do_access("rand", r_wr, r_addr, r_data, r_w, r_sq,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
